// File: rtl/counter_pkg.sv
// Shared types and constants for the button-driven count sequencer.
// Holds the FSM encoding, button indices and the saturating step helper.
package counter_pkg;

    localparam int COUNT_W = 32;
    localparam int IVL_W   = 16;
    localparam int BTN_W   = 5;

    localparam int BTN_FAST_DN = 0;
    localparam int BTN_UP      = 1;
    localparam int BTN_FAST_UP = 2;
    localparam int BTN_DN      = 3;
    localparam int BTN_CLR     = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT,
        ST_FAST,
        ST_LOCK
    } state_t;

    // Saturating +/-1; never wraps past 0 or max_val.
    function automatic logic [COUNT_W-1:0] sat_step(
        input logic [COUNT_W-1:0] cur,
        input logic               up,
        input logic [COUNT_W-1:0] max_val
    );
        if (up)
            return (cur < max_val) ? cur + COUNT_W'(1) : max_val;
        return (cur != '0) ? cur - COUNT_W'(1) : '0;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-bit tick-sampled debouncer.
// level_nxt exposes the post-tick level so the caller can act on the same edge.
module btn_debounce #(
    parameter int DEB_TICKS = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic level_nxt
);

    logic [3:0] run;
    logic [3:0] run_inc;
    logic       flip;

    assign run_inc   = run + 4'd1;
    assign flip      = tick && (raw != level) && (run_inc == 4'(DEB_TICKS));
    assign level_nxt = flip ? ~level : level;

    always_ff @(posedge clk) begin
        if (rst) begin
            run   <= '0;
            level <= 1'b0;
        end else if (tick) begin
            if (raw == level) begin
                run <= '0;
            end else if (flip) begin
                run   <= '0;
                level <= ~level;
            end else begin
                run <= run_inc;
            end
        end
    end

endmodule

// File: rtl/counter_step_sequencer.sv
// Debounced push-button sequencer owning the saturating 32-bit display count.
// Arbitrates step, hold-repeat, fast-run and clear on the 10 ms tick.
module counter_step_sequencer
    import counter_pkg::*;
#(
    parameter logic [COUNT_W-1:0] MAX_VAL       = 32'd99999999,
    parameter int                 DEB_TICKS     = 2,
    parameter int                 REPEAT_DELAY  = 50,
    parameter int                 REPEAT_PERIOD = 10
) (
    input  logic               IN_CLK,
    input  logic               IN_RST,
    input  logic               IN_TICK,
    input  logic               ENABLE,
    input  logic [BTN_W-1:0]   IN_BTN,
    output logic [COUNT_W-1:0] OUT_COUNT,
    output logic               OUT_AT_MAX,
    output logic               OUT_AT_MIN,
    output logic               OUT_REPEATING,
    output logic               OUT_LOCK
);

    logic               act;
    logic [BTN_W-1:0]   deb_q;
    logic [BTN_W-1:0]   deb_n;
    state_t             state;
    state_t             state_n;
    logic [IVL_W-1:0]   ivl;
    logic [IVL_W-1:0]   ivl_n;
    logic [IVL_W-1:0]   ivl_inc;
    logic [COUNT_W-1:0] count_n;
    logic               do_step;
    logic               step_up;
    logic               clr_rise;
    logic               multi;
    logic               hold_any;
    logic               fast_any;

    assign act = IN_TICK & ENABLE;

    for (genvar g = 0; g < BTN_W; g++) begin : g_deb
        btn_debounce #(
            .DEB_TICKS(DEB_TICKS)
        ) u_deb (
            .clk      (IN_CLK),
            .rst      (IN_RST),
            .tick     (act),
            .raw      (IN_BTN[g]),
            .level    (deb_q[g]),
            .level_nxt(deb_n[g])
        );
    end

    assign clr_rise = deb_n[BTN_CLR] & ~deb_q[BTN_CLR];
    assign multi    = $countones(deb_n[3:0]) > 1;
    assign hold_any = deb_n[BTN_UP] | deb_n[BTN_DN];
    assign fast_any = deb_n[BTN_FAST_UP] | deb_n[BTN_FAST_DN];
    assign ivl_inc  = ivl + IVL_W'(1);

    always_comb begin
        state_n = state;
        ivl_n   = ivl;
        do_step = 1'b0;
        step_up = 1'b0;
        if (clr_rise) begin
            state_n = ST_LOCK;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (multi) begin
                        state_n = ST_LOCK;
                    end else if (hold_any) begin
                        do_step = 1'b1;
                        step_up = deb_n[BTN_UP];
                        ivl_n   = '0;
                        state_n = ST_HOLD;
                    end else if (fast_any) begin
                        do_step = 1'b1;
                        step_up = deb_n[BTN_FAST_UP];
                        state_n = ST_FAST;
                    end
                end
                ST_HOLD, ST_REPEAT: begin
                    if (multi) begin
                        state_n = ST_LOCK;
                    end else if (!hold_any) begin
                        state_n = ST_IDLE;
                    end else begin
                        ivl_n = ivl_inc;
                        // HOLD waits the initial delay, REPEAT the period.
                        if (ivl_inc >= ((state == ST_HOLD)
                                ? IVL_W'(REPEAT_DELAY)
                                : IVL_W'(REPEAT_PERIOD))) begin
                            do_step = 1'b1;
                            step_up = deb_n[BTN_UP];
                            ivl_n   = '0;
                            state_n = ST_REPEAT;
                        end
                    end
                end
                ST_FAST: begin
                    if (multi) begin
                        state_n = ST_LOCK;
                    end else if (!fast_any) begin
                        state_n = ST_IDLE;
                    end else begin
                        do_step = 1'b1;
                        step_up = deb_n[BTN_FAST_UP];
                    end
                end
                ST_LOCK: begin
                    if (deb_n == '0)
                        state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        count_n = OUT_COUNT;
        if (clr_rise)
            count_n = '0;
        else if (do_step)
            count_n = sat_step(OUT_COUNT, step_up, MAX_VAL);
    end

    always_ff @(posedge IN_CLK) begin
        if (IN_RST) begin
            state         <= ST_IDLE;
            ivl           <= '0;
            OUT_COUNT     <= '0;
            OUT_AT_MAX    <= 1'b0;
            OUT_AT_MIN    <= 1'b1;
            OUT_REPEATING <= 1'b0;
            OUT_LOCK      <= 1'b0;
        end else if (act) begin
            state         <= state_n;
            ivl           <= ivl_n;
            OUT_COUNT     <= count_n;
            OUT_AT_MAX    <= (count_n == MAX_VAL);
            OUT_AT_MIN    <= (count_n == '0);
            OUT_REPEATING <= (state_n == ST_REPEAT) || (state_n == ST_FAST);
            OUT_LOCK      <= (state_n == ST_LOCK);
        end
    end

endmodule

// File: doc/counter_step_sequencer.md
Name: counter_step_sequencer

Overview:
Button-driven controller that owns the 32-bit count register for the board counter display path and sequences every change to it. It debounces the five push buttons on the 10 ms tick and arbitrates between single-step, hold-to-repeat, fast-run and clear requests. It enforces saturation bounds and presents the count plus status flags to the downstream binary-to-BCD / seven-segment / LED path.

Parameters:
MAX_VAL, 99999999, upper saturation bound (8 decimal digits)
DEB_TICKS, 2, consecutive identical tick samples needed to change a debounced button level (1..15)
REPEAT_DELAY, 50, ticks a single-step button is held before auto-repeat starts (0.5 s)
REPEAT_PERIOD, 10, ticks between auto-repeat steps (0.1 s)

Ports:
IN_CLK  in  1  system clock; all state on its rising edge
IN_RST  in  1  synchronous active-high reset
IN_TICK  in  1  one-IN_CLK-wide strobe every 10 ms (from ClkDiv_10ms, resynchronised upstream)
ENABLE  in  1  1 = sequencer active; 0 = freeze all state
IN_BTN  in  5  raw buttons: [1] step up, [3] step down, [2] fast up, [0] fast down, [4] clear
OUT_COUNT  out  32  current count, always in 0..MAX_VAL
OUT_AT_MAX  out  1  OUT_COUNT == MAX_VAL
OUT_AT_MIN  out  1  OUT_COUNT == 0
OUT_REPEATING  out  1  FSM in REPEAT or FAST
OUT_LOCK  out  1  FSM in LOCK (conflicting buttons)

Behaviour:
- Reset (IN_RST=1 at clock edge): OUT_COUNT=0, all debounced levels 0, debounce and interval counters 0, FSM=IDLE. Outputs: OUT_AT_MIN=1, all other flags 0. Reset overrides everything, including an in-flight repeat.
- All state advances only on edges where IN_TICK=1 and ENABLE=1. ENABLE=0 holds every register; IN_TICK is ignored.
- Debounce, per button: raw bit sampled each active tick. If the sample differs from the debounced level, a 4-bit run counter increments, otherwise it clears. When the run counter reaches DEB_TICKS, the debounced level flips and the counter clears.
- FSM decisions use the debounced levels as updated on the same tick (next-state value). A step is therefore applied on the same edge on which the debounced press is recognised.
- Clear has highest priority: a debounced rising edge of BTN[4] sets OUT_COUNT=0 and FSM=LOCK in any state.
- "Multi" means two or more of debounced BTN[3:0] are high.
- FSM states and transitions:
  - IDLE: multi -> LOCK, no step. Exactly one of [1]/[3] high -> step once, interval counter=0, -> HOLD. Exactly one of [2]/[0] high -> step once, -> FAST.
  - HOLD: button released -> IDLE. multi -> LOCK. Otherwise increment interval counter; when it reaches REPEAT_DELAY -> step, counter=0, -> REPEAT.
  - REPEAT: released -> IDLE. multi -> LOCK. Otherwise increment counter; on reaching REPEAT_PERIOD -> step, counter=0.
  - FAST: step every active tick while held. Released -> IDLE. multi -> LOCK.
  - LOCK: no steps; -> IDLE only on a tick where all debounced BTN[4:0] are 0.
- Step arithmetic (32-bit):
  - Up: if count < MAX_VAL then count+1, else hold at MAX_VAL.
  - Down: if count > 0 then count-1, else hold at 0.
  - No wrap-around. Saturation does not change FSM state; the button stays "held".
- OUT_AT_MAX / OUT_AT_MIN / OUT_REPEATING / OUT_LOCK are registered, consistent with OUT_COUNT and the FSM state after the same edge.
- Button bounce shorter than DEB_TICKS ticks produces no step.

Decomposition:
- Shared package counter_pkg: FSM state encoding (IDLE, HOLD, REPEAT, FAST, LOCK); button index constants BTN_FAST_DN=0, BTN_UP=1, BTN_FAST_UP=2, BTN_DN=3, BTN_CLR=4; COUNT_W=32.
- One sub-module, btn_debounce: single-bit debouncer with the DEB_TICKS parameter, instantiated 5 times.
- FSM, interval counter and saturating count register stay in the top module.

Test Plan:
(Bench: DEB_TICKS=2, REPEAT_DELAY=4, REPEAT_PERIOD=2, tick every 4 clocks.)
- Reset, then BTN[1] high for 3 ticks and released -> OUT_COUNT 0→1 on the 2nd tick, stays 1, FSM returns to IDLE, OUT_REPEATING=0.
- BTN[1] held 12 ticks from count 0 -> steps on ticks 2, 6, 8, 10, 12; final OUT_COUNT=5; OUT_REPEATING=1 from tick 6.
- Count preset to 99999998 via fast up, then BTN[2] held 5 ticks -> 99999999 after the first step; OUT_AT_MAX=1; no wrap on later ticks.
- At count 0, BTN[0] held 4 ticks -> OUT_COUNT stays 0, OUT_AT_MIN=1. BTN[1] and BTN[3] pressed together -> OUT_LOCK=1, no step until both released.
- Count=7: BTN[4] pulse 2 ticks while BTN[2] held -> OUT_COUNT=0, LOCK; IDLE only after all buttons released. ENABLE=0 for 10 ticks with BTN[2] held -> count frozen.
- 1-tick glitch on BTN[3] -> no change. Assert IN_RST mid-REPEAT -> next edge OUT_COUNT=0, FSM=IDLE.
